memc_deskew: RTL
================

Name: memc_deskew

Overview:
- Output-side counterpart to the skewed A/B row-loaders feeding the systolic MAC array.
- Captures the skewed result stream leaving the array: lane j carries C[r][j] on enabled cycle r+j.
- Removes the skew with per-lane delay lines and stores aligned rows into a DIM x DIM result buffer.
- The host reads the buffer one row at a time by address.

Parameters:
- BITS_C, 24, signed width of one result element.
- DIM, 8, array dimension: number of lanes and number of rows captured.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  arm pulse; IDLE/DONE -> FILL and clears counters.
- en  input  1  stream-advance qualifier; delay lines and counters move only when en=1.
- Cin  input  signed [BITS_C-1:0] x DIM  skewed result lanes from the array edge.
- Crow  input  $clog2(DIM)  row address for readback.
- Cout  output  signed [BITS_C-1:0] x DIM  registered row read data.
- busy  output  1  high in FILL or CAPTURE.
- done  output  1  high in DONE, after all DIM rows are stored.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters=0.
  - All delay-line stages, buffer entries and Cout = 0.
  - busy=0, done=0.
- Deskew:
  - Lane j passes through a shift register of depth DIM-1-j; lane DIM-1 has depth 0 (wire).
  - A stage shifts only when en=1.
  - For input row r, all aligned lanes present C[r][*] together on enabled cycle r+DIM-1, counted from the first enabled cycle after start.
- Counters:
  - cyc_cnt counts enabled cycles in FILL, 0..DIM-2.
  - wr_row counts rows written in CAPTURE, 0..DIM-1.
- States:
  - IDLE: waits for start.
  - FILL:
    - Each en increments cyc_cnt.
    - When en=1 and cyc_cnt==DIM-2, go to CAPTURE. For DIM=1, skip FILL and go straight to CAPTURE.
  - CAPTURE:
    - Each en writes the aligned lanes into buf[wr_row] and increments wr_row.
    - When en=1 and wr_row==DIM-1, go to DONE.
  - DONE:
    - Holds the buffer.
    - start re-arms: go to FILL, clear counters. The buffer is not cleared; it is overwritten row by row.
- Stall: en=0 in FILL or CAPTURE freezes delay lines, counters and state; no data is lost.
- start while busy: ignored (no restart mid-capture).
- Total capture: exactly 2*DIM-1 enabled cycles after start. done rises the cycle after the last enabled CAPTURE cycle.
- Readback:
  - Cout <= buf[Crow] every cycle, 1-cycle latency, in every state.
  - Reading a row while it is being written in the same cycle returns the old contents.
- Cin lanes beyond the valid skew window (pre-row-0 / post-row-DIM-1 zeros) are shifted in but never written.
- No arithmetic is performed; the width is passed through unchanged and sign is preserved.
- Reset mid-capture aborts immediately to IDLE with everything zeroed.

Decomposition:
- Shared package (systolic_pkg): BITS_C default, state enum (IDLE, FILL, CAPTURE, DONE), and a DIM-indexed row type.
- One sub-module: deskew_delay, a parameterised DEPTH/BITS shift register with enable and async reset, instantiated per lane via generate.
  - DEPTH=0 is handled as a pass-through.

Test Plan:
- Reset: assert rst_n=0 mid-sim -> Cout all 0, busy=0, done=0, state IDLE; re-read every row -> all 0.
- Nominal fill (DIM=4):
  - Stimulus: start, then 7 en cycles driving a skewed stream of C[r][j]=16*r+j, with zeros outside the window.
  - Response: done=1 on the 8th cycle; Crow=0..3 return {0,1,2,3}, {16,17,18,19}, {32,...,35}, {48,...,51}, each 1 cycle after the address.
- Stall: same stream with en=0 inserted for 3 cycles after cycle 2 and cycle 5 -> identical buffer contents; done is delayed by exactly 6 cycles.
- Signed data: C[r][j] = -(r*DIM+j+1), e.g. -1 and -16 at BITS_C=24 -> readback 24'hFFFFFF and 24'hFFFFF0; sign is preserved.
- Restart/ignore:
  - start pulse during CAPTURE -> no effect, done still after 2*DIM-1 enables.
  - After done, start plus a new stream with value+100 -> rows are overwritten, done deasserts at start and reasserts.
- Reset mid-operation: rst_n low after 3 enabled CAPTURE cycles -> buffer is zero and state is IDLE; a full new capture then completes correctly.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array output path.
package systolic_pkg;

  localparam int BITS_C_DEF = 24;
  localparam int DIM_DEF    = 8;

  typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DONE} state_t;

  typedef logic [DIM_DEF-1:0][BITS_C_DEF-1:0] row_t;

  // Address width that stays legal for a single-row array.
  function automatic int addrBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memc_deskew_if.sv
// Host/array-facing bundle of the result deskew buffer.
interface memc_deskew_if
  import systolic_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int BITS_C = BITS_C_DEF
);

  localparam int AW = addrBits(DIM);

  logic                         start;
  logic                         en;
  logic [DIM-1:0][BITS_C-1:0]   Cin;
  logic [AW-1:0]                Crow;
  logic [DIM-1:0][BITS_C-1:0]   Cout;
  logic                         busy;
  logic                         done;

  modport master (output start, en, Cin, Crow, input Cout, busy, done);
  modport slave  (input start, en, Cin, Crow, output Cout, busy, done);

endinterface

// File: rtl/deskew_delay.sv
// Enable-qualified shift register; DEPTH=0 degenerates to a wire.
module deskew_delay #(
  parameter int DEPTH = 1,
  parameter int BITS  = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [BITS-1:0] d_i,
  output logic [BITS-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unusedTieOff;
    assign unusedTieOff = ^{clk, rst_n, en_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0][BITS-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/memc_deskew.sv
// Realigns the skewed result stream of the MAC array into a row buffer
// that the host reads back one row per address.
module memc_deskew
  import systolic_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int BITS_C = BITS_C_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  memc_deskew_if.slave  bus
);

  localparam int AW = addrBits(DIM);
  localparam logic [AW-1:0] CYC_LAST = AW'((DIM > 1) ? (DIM - 2) : 0);
  localparam logic [AW-1:0] ROW_LAST = AW'(DIM - 1);

  typedef logic [DIM-1:0][BITS_C-1:0] lanes_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cycCnt_q, cycCnt_d;
  logic [AW-1:0] wrRow_q, wrRow_d;
  logic          wrEn;
  lanes_t        aligned;
  lanes_t        rowBuf_q [DIM];
  lanes_t        cout_q;

  // Lane j arrives j cycles late, so it is held back DIM-1-j enabled cycles.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    deskew_delay #(
      .DEPTH (DIM - 1 - j),
      .BITS  (BITS_C)
    ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (bus.en),
      .d_i   (bus.Cin[j]),
      .q_o   (aligned[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cycCnt_q <= '0;
      wrRow_q  <= '0;
    end else begin
      state_q  <= state_d;
      cycCnt_q <= cycCnt_d;
      wrRow_q  <= wrRow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cycCnt_d = cycCnt_q;
    wrRow_d  = wrRow_q;
    wrEn     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          cycCnt_d = '0;
          wrRow_d  = '0;
          state_d  = (DIM == 1) ? CAPTURE : FILL;
        end
      end
      FILL: begin
        if (bus.en) begin
          cycCnt_d = cycCnt_q + AW'(1);
          if (cycCnt_q == CYC_LAST) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.en) begin
          wrEn    = 1'b1;
          wrRow_d = wrRow_q + AW'(1);
          if (wrRow_q == ROW_LAST) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readback samples the pre-write contents when address and write collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) rowBuf_q[i] <= '0;
      cout_q <= '0;
    end else begin
      if (wrEn) rowBuf_q[wrRow_q] <= aligned;
      cout_q <= rowBuf_q[bus.Crow];
    end
  end

  assign bus.Cout = cout_q;
  assign bus.busy = (state_q == FILL) || (state_q == CAPTURE);
  assign bus.done = (state_q == DONE);

endmodule
